// File: rtl/div_iter.sv
// div_iter: multi-cycle restoring divider, STEP quotient bits per cycle, signed/unsigned with divide-by-zero flag
module div_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_by_zero_o
);
  localparam int N = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] dvd, dvs, rem, r_nx, d_nx, a_abs, b_abs;
  logic [WIDTH:0] sh, tr;
  logic [CW-1:0] cnt;
  logic neg_q, neg_r, a_neg, b_neg;
  assign a_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign b_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign a_abs = a_neg ? -opdata1_i : opdata1_i;
  assign b_abs = b_neg ? -opdata2_i : opdata2_i;
  // dvd shifts dividend bits out of the top while quotient bits enter at the bottom
  always_comb begin
    r_nx = rem;
    d_nx = dvd;
    sh = '0;
    tr = '0;
    for (int i = 0; i < STEP; i++) begin
      sh = {r_nx, d_nx[WIDTH-1]};
      tr = sh - {1'b0, dvs};
      d_nx = {d_nx[WIDTH-2:0], ~tr[WIDTH]};
      r_nx = tr[WIDTH] ? sh[WIDTH-1:0] : tr[WIDTH-1:0];
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      result_o <= '0;
      ready_o <= 1'b0;
      busy_o <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state <= DONE;
            result_o <= {opdata1_i, {WIDTH{1'b1}}};
            ready_o <= 1'b1;
            div_by_zero_o <= 1'b1;
          end else begin
            state <= CALC;
            dvd <= a_abs;
            dvs <= b_abs;
            rem <= '0;
            cnt <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            busy_o <= 1'b1;
          end
        end
        CALC: if (annul_i) begin
          state <= IDLE;
          busy_o <= 1'b0;
        end else begin
          rem <= r_nx;
          dvd <= d_nx;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          state <= annul_i ? IDLE : DONE;
          busy_o <= 1'b0;
          if (!annul_i) begin
            result_o <= {neg_r ? -rem : rem, neg_q ? -dvd : dvd};
            ready_o <= 1'b1;
          end
        end
        default: if (annul_i || !start_i) begin
          state <= IDLE;
          result_o <= '0;
          ready_o <= 1'b0;
          div_by_zero_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: randomized and directed checks of div_iter against an arithmetic reference
module tb_div_iter;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic sg = 1'b0, st32 = 1'b0, st16 = 1'b0, an = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [63:0] r32;
  logic [31:0] r16;
  logic rdy32, bsy32, dz32, rdy16, bsy16, dz16;
  int errs = 0, checks = 0;

  div_iter #(.WIDTH(32), .STEP(1)) u32 (
    .clk(clk), .rst(rst), .signed_div_i(sg), .opdata1_i(a), .opdata2_i(b),
    .start_i(st32), .annul_i(an), .result_o(r32), .ready_o(rdy32),
    .busy_o(bsy32), .div_by_zero_o(dz32));

  div_iter #(.WIDTH(16), .STEP(4)) u16 (
    .clk(clk), .rst(rst), .signed_div_i(sg), .opdata1_i(a[15:0]), .opdata2_i(b[15:0]),
    .start_i(st16), .annul_i(an), .result_o(r16), .ready_o(rdy16),
    .busy_o(bsy16), .div_by_zero_o(dz16));

  // returns {dbz, remainder, quotient} using plain 64-bit arithmetic
  function automatic logic [64:0] model(input int w, input bit s, input logic [31:0] x, input logic [31:0] y);
    longint m, sx, sy, q, r;
    m = (longint'(1) << w) - 1;
    sx = longint'(x) & m;
    sy = longint'(y) & m;
    if (sy == 0) return {1'b1, x & m[31:0], m[31:0]};
    if (s && sx[w-1]) sx = sx - (m + 1);
    if (s && sy[w-1]) sy = sy - (m + 1);
    q = sx / sy;
    r = sx % sy;
    return {1'b0, r[31:0] & m[31:0], q[31:0] & m[31:0]};
  endfunction

  task automatic op(input bit sm, input bit s, input logic [31:0] x, input logic [31:0] y,
                    input bit early, input string nm);
    logic [64:0] e;
    logic [63:0] got;
    int n, bc, lat, bexp;
    e = model(sm ? 16 : 32, s, x, y);
    lat = e[64] ? 1 : (sm ? 6 : 34);
    bexp = e[64] ? 0 : (sm ? 5 : 33);
    @(negedge clk);
    sg = s; a = x; b = y;
    if (sm) st16 = 1'b1; else st32 = 1'b1;
    @(posedge clk); #1;
    n = 1; bc = 0;
    while (!(sm ? rdy16 : rdy32) && n < 100) begin
      if (sm ? bsy16 : bsy32) bc++;
      if (n == 2) begin a = $urandom; b = $urandom; sg = ~sg; end
      if (early && n == 3) begin st16 = 1'b0; st32 = 1'b0; end
      @(posedge clk); #1;
      n++;
    end
    got = sm ? {16'h0, r16[31:16], 16'h0, r16[15:0]} : r32;
    checks++;
    if (n !== lat) begin errs++; $display("FAIL %s latency got %0d exp %0d", nm, n, lat); end
    checks++;
    if (got !== e[63:0]) begin errs++; $display("FAIL %s result got %h exp %h", nm, got, e[63:0]); end
    checks++;
    if ((sm ? dz16 : dz32) !== e[64]) begin errs++; $display("FAIL %s dbz got %b exp %b", nm, sm ? dz16 : dz32, e[64]); end
    checks++;
    if (bc !== bexp) begin errs++; $display("FAIL %s busy_cycles got %0d exp %0d", nm, bc, bexp); end
    @(negedge clk);
    st16 = 1'b0; st32 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({rdy32, dz32, bsy32, r32, rdy16, dz16, bsy16, r16} !== '0)
      begin errs++; $display("FAIL %s exit got rdy32=%b rdy16=%b r32=%h r16=%h exp zeros", nm, rdy32, rdy16, r32, r16); end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({rdy32, bsy32, dz32, r32} !== '0) begin errs++; $display("FAIL reset32 got %b%b%b %h exp 0", rdy32, bsy32, dz32, r32); end
    checks++;
    if ({rdy16, bsy16, dz16, r16} !== '0) begin errs++; $display("FAIL reset16 got %b%b%b %h exp 0", rdy16, bsy16, dz16, r16); end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_directed;
    op(0, 0, 32'd100, 32'd7, 0, "u100_7");
    op(0, 1, 32'hFFFFFFF9, 32'd2, 0, "s-7_2");
    op(0, 1, 32'd7, 32'hFFFFFFFE, 0, "s7_-2");
    op(0, 0, 32'd5, 32'd0, 0, "dbz5");
    op(0, 1, 32'h80000000, 32'hFFFFFFFF, 0, "smin_m1");
    op(0, 0, 32'h80000000, 32'hFFFFFFFF, 0, "umin_m1");
    op(0, 0, 32'hFFFFFFFF, 32'd1, 0, "umax_1");
  endtask

  task automatic test_start_drop;
    op(0, 1, 32'hFFFF0000, 32'd12345, 1, "drop32");
    op(1, 0, 32'd60000, 32'd7, 1, "drop16");
  endtask

  task automatic test_annul;
    int n;
    bit seen;
    @(negedge clk);
    sg = 1'b0; a = 32'd1234567; b = 32'd89; st32 = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (bsy32 !== 1'b1) begin errs++; $display("FAIL annul_pre_busy got %b exp 1", bsy32); end
    @(negedge clk); an = 1'b1; st32 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bsy32, rdy32} !== 2'b00) begin errs++; $display("FAIL annul_calc got busy=%b rdy=%b exp 0 0", bsy32, rdy32); end
    @(negedge clk); an = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (rdy32 || bsy32) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errs++; $display("FAIL annul_quiet got activity=%b exp 0", seen); end
    op(0, 0, 32'hFFFFFFFF, 32'h10, 0, "after_annul");
    // annul landing on the fix-up cycle must suppress the result
    @(negedge clk);
    a = 32'd999; b = 32'd3; st32 = 1'b1;
    @(posedge clk);
    repeat (32) @(posedge clk);
    #1;
    checks++;
    if ({bsy32, rdy32} !== 2'b10) begin errs++; $display("FAIL fix_state got busy=%b rdy=%b exp 1 0", bsy32, rdy32); end
    @(negedge clk); an = 1'b1; st32 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bsy32, rdy32, r32} !== '0) begin errs++; $display("FAIL annul_fix got busy=%b rdy=%b r=%h exp 0", bsy32, rdy32, r32); end
    @(negedge clk); an = 1'b0;
    // annul while DONE with start still high
    @(negedge clk);
    a = 32'd50; b = 32'd0; st32 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rdy32, dz32} !== 2'b11) begin errs++; $display("FAIL done_pre got rdy=%b dbz=%b exp 1 1", rdy32, dz32); end
    @(negedge clk); an = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rdy32, dz32, r32} !== '0) begin errs++; $display("FAIL annul_done got rdy=%b dbz=%b r=%h exp 0", rdy32, dz32, r32); end
    @(negedge clk); an = 1'b0; st32 = 1'b0;
    n = 0;
  endtask

  task automatic test_width16;
    op(1, 0, 32'd1000, 32'd3, 0, "w16_1000_3");
    op(1, 1, 32'h00008000, 32'h0000FFFF, 0, "w16_smin_m1");
    op(1, 1, 32'h0000FFF9, 32'd2, 0, "w16_s-7_2");
    op(1, 0, 32'd5, 32'd0, 0, "w16_dbz");
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    sg = 1'b0; a = 32'd1000; b = 32'd3; st16 = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (bsy16 !== 1'b1) begin errs++; $display("FAIL rstmid_busy got %b exp 1", bsy16); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({rdy16, bsy16, dz16, r16} !== '0) begin errs++; $display("FAIL rstmid got rdy=%b busy=%b r=%h exp 0", rdy16, bsy16, r16); end
    @(negedge clk); st16 = 1'b0; rst = 1'b1;
  endtask

  task automatic test_random;
    bit sm, s;
    int k;
    logic [31:0] x, y;
    for (int i = 0; i < 60; i++) begin
      sm = bit'($urandom_range(0, 1));
      s = bit'($urandom_range(0, 1));
      k = $urandom_range(0, 7);
      x = $urandom;
      y = (k == 0) ? 32'd0 : (k == 1) ? 32'hFFFFFFFF : (k == 2) ? 32'($urandom_range(1, 15)) : $urandom;
      if (k == 1 && $urandom_range(0, 1) == 1) x = sm ? 32'h00008000 : 32'h80000000;
      op(sm, s, x, y, $urandom_range(0, 3) == 0, $sformatf("rnd%0d", i));
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_start_drop;
    test_annul;
    test_width16;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
